// File: rtl/chacha_qr_core.sv
// Iterative ChaCha quarter-round engine: one ARX step per clock, four steps per
// quarter-round, NUM_QR quarter-rounds back-to-back per start.
module chacha_qr_core #(
   parameter int NUM_QR = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic [31:0] c_in,
   input  logic [31:0] d_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] a_out,
   output logic [31:0] b_out,
   output logic [31:0] c_out,
   output logic [31:0] d_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_QR = 5'(NUM_QR - 1);

   state_t      state_r, state_s;
   logic [31:0] wa_r, wb_r, wc_r, wd_r;
   logic [31:0] na_s, nb_s, nc_s, nd_s;
   logic [31:0] sum_ab_s, sum_cd_s;
   logic [1:0]  step_r;
   logic [4:0]  qr_r;
   logic        last_step_s;
   logic        accept_s;
   logic        advance_s;
   logic        busy_s, done_s;
   logic        busy_r, done_r;
   logic [31:0] a_out_r, b_out_r, c_out_r, d_out_r;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      return (x << n) | (x >> (6'd32 - {1'b0, n}));
   endfunction

   assign sum_ab_s    = wa_r + wb_r;
   assign sum_cd_s    = wc_r + wd_r;
   assign last_step_s = (step_r == 2'd3) && (qr_r == LAST_QR);
   assign accept_s    = (state_r != RUN) && start;
   assign advance_s   = (state_r == RUN) && !abort;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; abort in RUN takes priority over completion.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = RUN;
            else       state_s = IDLE;
         end
         RUN: begin
            if (abort)            state_s = IDLE;
            else if (last_step_s) state_s = DONE;
            else                  state_s = RUN;
         end
         DONE: begin
            if (start) state_s = RUN;
            else       state_s = IDLE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state, registered below.
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_s)
         IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
         RUN:     begin busy_s = 1'b1; done_s = 1'b0; end
         DONE:    begin busy_s = 1'b0; done_s = 1'b1; end
         default: begin busy_s = 1'b0; done_s = 1'b0; end
      endcase
   end

   // Handshake output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
      end
   end

   // One ARX step of the quarter-round selected by the step counter.
   always_comb begin
      na_s = wa_r;
      nb_s = wb_r;
      nc_s = wc_r;
      nd_s = wd_r;
      case (step_r)
         2'd0: begin na_s = sum_ab_s; nd_s = rotl(wd_r ^ sum_ab_s, 5'd16); end
         2'd1: begin nc_s = sum_cd_s; nb_s = rotl(wb_r ^ sum_cd_s, 5'd12); end
         2'd2: begin na_s = sum_ab_s; nd_s = rotl(wd_r ^ sum_ab_s, 5'd8);  end
         2'd3: begin nc_s = sum_cd_s; nb_s = rotl(wb_r ^ sum_cd_s, 5'd7);  end
         default: begin na_s = wa_r; nb_s = wb_r; nc_s = wc_r; nd_s = wd_r; end
      endcase
   end

   // Working registers and step/round counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wa_r   <= 32'd0;
         wb_r   <= 32'd0;
         wc_r   <= 32'd0;
         wd_r   <= 32'd0;
         step_r <= 2'd0;
         qr_r   <= 5'd0;
      end else if (accept_s) begin
         wa_r   <= a_in;
         wb_r   <= b_in;
         wc_r   <= c_in;
         wd_r   <= d_in;
         step_r <= 2'd0;
         qr_r   <= 5'd0;
      end else if (advance_s) begin
         wa_r   <= na_s;
         wb_r   <= nb_s;
         wc_r   <= nc_s;
         wd_r   <= nd_s;
         step_r <= step_r + 2'd1;
         if ((step_r == 2'd3) && !last_step_s) qr_r <= qr_r + 5'd1;
      end
   end

   // Result registers update only on the completion edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out_r <= 32'd0;
         b_out_r <= 32'd0;
         c_out_r <= 32'd0;
         d_out_r <= 32'd0;
      end else if (advance_s && last_step_s) begin
         a_out_r <= na_s;
         b_out_r <= nb_s;
         c_out_r <= nc_s;
         d_out_r <= nd_s;
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign a_out = a_out_r;
   assign b_out = b_out_r;
   assign c_out = c_out_r;
   assign d_out = d_out_r;

endmodule

// File: tb/tb_chacha_qr_core.sv
// Directed bench for chacha_qr_core: one instance with NUM_QR=1 and one with
// NUM_QR=2, sharing operands and abort but started independently.
module tb_chacha_qr_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0, start2 = 1'b0, abort = 1'b0;
   logic [31:0] a_in = 32'd0, b_in = 32'd0, c_in = 32'd0, d_in = 32'd0;
   logic        busy1, done1, busy2, done2;
   logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   chacha_qr_core #(.NUM_QR(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
      .busy(busy1), .done(done1),
      .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1)
   );

   chacha_qr_core #(.NUM_QR(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
      .busy(busy2), .done(done2),
      .a_out(a2), .b_out(b2), .c_out(c2), .d_out(d2)
   );

   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      case (n)
         16:      return {x[15:0], x[31:16]};
         12:      return {x[19:0], x[31:20]};
         8:       return {x[23:0], x[31:24]};
         7:       return {x[24:0], x[31:25]};
         default: return x;
      endcase
   endfunction

   // Textbook quarter-round on {a,b,c,d}.
   function automatic logic [127:0] qr_model(input logic [127:0] s);
      logic [31:0] a, b, c, d;
      {a, b, c, d} = s;
      a = a + b; d = rl(d ^ a, 16);
      c = c + d; b = rl(b ^ c, 12);
      a = a + b; d = rl(d ^ a, 8);
      c = c + d; b = rl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input logic [127:0] v);
      {a_in, b_in, c_in, d_in} = v;
   endtask

   // Called just after the start edge; counts edges until done, bounded.
   task automatic wait_done(input int which, output int cyc, output int busy_cnt);
      cyc = 0;
      busy_cnt = 0;
      while (cyc < 40) begin
         if ((which == 1) ? busy1 : busy2) busy_cnt++;
         tick();
         cyc++;
         if ((which == 1) ? done1 : done2) break;
      end
   endtask

   localparam logic [127:0] RFC_IN  = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
   localparam logic [127:0] RFC_OUT = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
   localparam logic [127:0] WRAP_IN  = {32'hffffffff, 32'h00000001, 32'h00000000, 32'h00000000};
   localparam logic [127:0] WRAP_OUT = {32'h00001000, 32'h08080000, 32'h00100000, 32'h00100000};
   localparam logic [127:0] ALT_IN  = {32'hdeadbeef, 32'hcafef00d, 32'h0badc0de, 32'h12345678};

   initial begin
      int cyc, bcnt;
      logic [127:0] held;

      // Reset state
      #12;
      chk("rst_busy_done", {126'd0, busy1, done1}, 128'd0);
      chk("rst_out1", {a1, b1, c1, d1}, 128'd0);
      chk("rst_out2", {a2, b2, c2, d2}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: RFC 8439 2.1.1 vector, NUM_QR=1
      set_ops(RFC_IN);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      set_ops(128'd0);
      wait_done(1, cyc, bcnt);
      chk("rfc_latency", 128'(cyc), 128'd4);
      chk("rfc_busy_cycles", 128'(bcnt), 128'd4);
      chk("rfc_done_busy", {126'd0, done1, busy1}, 128'd2);
      chk("rfc_result", {a1, b1, c1, d1}, RFC_OUT);
      tick();
      chk("rfc_done_pulse", {127'd0, done1}, 128'd0);

      // 2: NUM_QR=2 on the same operands
      set_ops(RFC_IN);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      wait_done(2, cyc, bcnt);
      chk("qr2_latency", 128'(cyc), 128'd8);
      chk("qr2_busy_cycles", 128'(bcnt), 128'd8);
      chk("qr2_result", {a2, b2, c2, d2}, qr_model(qr_model(RFC_IN)));
      tick();

      // 3: carry/wrap operands
      set_ops(WRAP_IN);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done(1, cyc, bcnt);
      chk("wrap_latency", 128'(cyc), 128'd4);
      chk("wrap_result", {a1, b1, c1, d1}, WRAP_OUT);
      tick();

      // 4: start pulses while busy are ignored
      set_ops(RFC_IN);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      set_ops(ALT_IN);
      tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("busy_ignore_held", {a1, b1, c1, d1}, WRAP_OUT);
      tick();
      tick();
      chk("busy_ignore_done", {126'd0, done1, busy1}, 128'd2);
      chk("busy_ignore_result", {a1, b1, c1, d1}, RFC_OUT);
      bcnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done1 || busy1) bcnt++;
      end
      chk("busy_ignore_single_done", 128'(bcnt), 128'd0);

      // 5: back-to-back, start accepted in the DONE cycle
      set_ops(WRAP_IN);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done(1, cyc, bcnt);
      chk("b2b_first", {a1, b1, c1, d1}, WRAP_OUT);
      held = {a1, b1, c1, d1};
      set_ops(ALT_IN);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("b2b_accept_busy", {127'd0, busy1}, 128'd1);
      chk("b2b_held", {a1, b1, c1, d1}, held);
      wait_done(1, cyc, bcnt);
      chk("b2b_latency", 128'(cyc), 128'd4);
      chk("b2b_result", {a1, b1, c1, d1}, qr_model(ALT_IN));
      tick();

      // 6a: abort before step 2 executes
      held = {a1, b1, c1, d1};
      set_ops(RFC_IN);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy_done", {126'd0, busy1, done1}, 128'd0);
      chk("abort_out_held", {a1, b1, c1, d1}, held);
      bcnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done1) bcnt++;
      end
      chk("abort_no_done", 128'(bcnt), 128'd0);

      // 6b: abort and start together in IDLE, start wins
      set_ops(WRAP_IN);
      start1 = 1'b1;
      abort = 1'b1;
      tick();
      start1 = 1'b0;
      abort = 1'b0;
      chk("abort_start_idle", {127'd0, busy1}, 128'd1);
      wait_done(1, cyc, bcnt);
      chk("abort_start_result", {a1, b1, c1, d1}, WRAP_OUT);
      tick();

      // 6c: asynchronous reset mid-run
      set_ops(RFC_IN);
      start1 = 1'b1;
      start2 = 1'b1;
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ctrl", {124'd0, busy1, done1, busy2, done2}, 128'd0);
      chk("arst_out1", {a1, b1, c1, d1}, 128'd0);
      chk("arst_out2", {a2, b2, c2, d2}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done1 || done2 || busy1 || busy2) bcnt++;
      end
      chk("arst_quiet", 128'(bcnt), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
